// File: rtl/control_unit_module_pkg.sv
// Shared definitions for the multicycle RV32I control unit: states, opcodes,
// ALU / immediate / access-size codes and small funct3 decode helpers.
package control_unit_module_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_RD    = 4'd3,
        S_LOAD_WB   = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_LUI_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_EXEC_JALR = 4'd11,
        S_JUMP_LINK = 4'd12,
        S_JUMP      = 4'd13,
        S_HALT      = 4'd14
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [3:0] IMM_I   = 4'd0;
    localparam logic [3:0] IMM_S   = 4'd1;
    localparam logic [3:0] IMM_B   = 4'd2;
    localparam logic [3:0] IMM_U   = 4'd3;
    localparam logic [3:0] IMM_J   = 4'd4;
    localparam logic [3:0] IMM_LB  = 4'd5;
    localparam logic [3:0] IMM_LH  = 4'd6;
    localparam logic [3:0] IMM_LW  = 4'd7;
    localparam logic [3:0] IMM_LBU = 4'd8;
    localparam logic [3:0] IMM_LHU = 4'd9;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;

    localparam logic [1:0] OP1_RS1    = 2'b00;
    localparam logic [1:0] OP1_PC     = 2'b01;
    localparam logic [1:0] OP1_OLD_PC = 2'b10;
    localparam logic [1:0] OP2_IMM    = 2'b00;
    localparam logic [1:0] OP2_FOUR   = 2'b01;
    localparam logic [1:0] OP2_RS2    = 2'b10;

    localparam logic [1:0] RF_MEM  = 2'b00;
    localparam logic [1:0] RF_ALU  = 2'b01;
    localparam logic [1:0] RF_SEXT = 2'b10;

    function automatic logic [1:0] mode_from_funct3(input logic [2:0] f3);
        logic [1:0] m;
        case (f3[1:0])
            2'b00:   m = MODE_BYTE;
            2'b01:   m = MODE_HALF;
            default: m = MODE_WORD;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] load_ext_from_funct3(input logic [2:0] f3);
        logic [3:0] s;
        case (f3)
            3'b000:  s = IMM_LB;
            3'b001:  s = IMM_LH;
            3'b100:  s = IMM_LBU;
            3'b101:  s = IMM_LHU;
            default: s = IMM_LW;
        endcase
        return s;
    endfunction

    // SUB gives zero on equality; SLT/SLTU give zero when rs1 >= rs2.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        logic t;
        case (f3)
            3'b000:  t = zero;
            3'b001:  t = ~zero;
            3'b100:  t = ~zero;
            3'b101:  t = zero;
            3'b110:  t = ~zero;
            3'b111:  t = zero;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/control_unit_module_alu_decoder.sv
// Combinational ALU-operation decoder from opcode, funct3 and funct7[5].
module alu_decoder_module
    import control_unit_module_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] alu_sel_o
);

    // Register-register and immediate ops share funct3 meaning; only ADD/SUB differs.
    always_comb begin
        alu_sel_o = ALU_ADD;
        if ((opcode_i == OPC_OP) || (opcode_i == OPC_OP_IMM)) begin
            case (funct3_i)
                3'b000:  alu_sel_o = ((opcode_i == OPC_OP) && funct7_5_i) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_sel_o = ALU_SLL;
                3'b010:  alu_sel_o = ALU_SLT;
                3'b011:  alu_sel_o = ALU_SLTU;
                3'b100:  alu_sel_o = ALU_XOR;
                3'b101:  alu_sel_o = funct7_5_i ? ALU_SRA : ALU_SRL;
                3'b110:  alu_sel_o = ALU_OR;
                3'b111:  alu_sel_o = ALU_AND;
                default: alu_sel_o = ALU_ADD;
            endcase
        end else if (opcode_i == OPC_BRANCH) begin
            case (funct3_i[2:1])
                2'b10:   alu_sel_o = ALU_SLT;
                2'b11:   alu_sel_o = ALU_SLTU;
                default: alu_sel_o = ALU_SUB;
            endcase
        end else begin
            alu_sel_o = ALU_ADD;
        end
    end

endmodule

// File: rtl/control_unit_module.sv
// Multicycle control FSM sequencing the RV32I datapath; outputs are decoded
// combinationally from the current state and forced low while reset is held.
module control_unit_module
    import control_unit_module_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_reg_out,
    input  logic        zero,
    input  logic        mem_op_r,
    output logic        pc_enable,
    output logic        old_pc_enable,
    output logic        ir_reg_enable,
    output logic        mem_reg_enable,
    output logic        alu_reg_enable,
    output logic        rf_we,
    output logic        mem_enable,
    output logic        mem_write_enable,
    output logic        memsel_mux_select,
    output logic        alu_reg_mux_select,
    output logic [1:0]  regfile_mux_select,
    output logic [3:0]  imm_src,
    output logic [1:0]  opsel1_select,
    output logic [1:0]  opsel2_select,
    output logic [3:0]  alu_sel,
    output logic [1:0]  instr_mode,
    output logic        halted,
    output logic [31:0] instret
);

    state_t      state_q, state_d;
    logic        halted_q;
    logic [31:0] instret_q;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [3:0]  dec_alu_s;
    logic        unused_ir_s;

    logic        pc_en_s, old_pc_en_s, ir_en_s, mem_reg_en_s, alu_reg_en_s;
    logic        rf_we_s, mem_en_s, mem_we_s, memsel_s, arm_s;
    logic [1:0]  rfm_s, op1_s, op2_s, mode_s;
    logic [3:0]  imm_s, alu_s;

    assign opcode_s    = ir_reg_out[6:0];
    assign funct3_s    = ir_reg_out[14:12];
    assign unused_ir_s = ^{ir_reg_out[31], ir_reg_out[29:15], ir_reg_out[11:7]};

    alu_decoder_module u_alu_dec (
        .opcode_i   (opcode_s),
        .funct3_i   (funct3_s),
        .funct7_5_i (ir_reg_out[30]),
        .alu_sel_o  (dec_alu_s)
    );

    // State, sticky halt flag and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            halted_q  <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_q | (state_d == S_HALT);
            if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
                instret_q <= instret_q + 32'd1;
            end else begin
                instret_q <= instret_q;
            end
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d      = state_q;
        pc_en_s      = 1'b0;
        old_pc_en_s  = 1'b0;
        ir_en_s      = 1'b0;
        mem_reg_en_s = 1'b0;
        alu_reg_en_s = 1'b0;
        rf_we_s      = 1'b0;
        mem_en_s     = 1'b0;
        mem_we_s     = 1'b0;
        memsel_s     = 1'b0;
        arm_s        = 1'b0;
        rfm_s        = RF_MEM;
        imm_s        = IMM_I;
        op1_s        = OP1_RS1;
        op2_s        = OP2_IMM;
        alu_s        = ALU_ADD;
        mode_s       = MODE_WORD;
        case (state_q)
            S_FETCH: begin
                mem_en_s = 1'b1;
                if (mem_op_r) begin
                    ir_en_s     = 1'b1;
                    old_pc_en_s = 1'b1;
                    pc_en_s     = 1'b1;
                    op1_s       = OP1_PC;
                    op2_s       = OP2_FOUR;
                    arm_s       = 1'b1;
                    state_d     = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_reg_en_s = 1'b1;
                op1_s        = OP1_OLD_PC;
                op2_s        = OP2_IMM;
                imm_s        = (opcode_s == OPC_JAL) ? IMM_J :
                               (opcode_s == OPC_BRANCH) ? IMM_B : IMM_U;
                case (opcode_s)
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADR;
                    OPC_OP:              state_d = S_EXEC_R;
                    OPC_OP_IMM:          state_d = S_EXEC_I;
                    OPC_BRANCH:          state_d = S_BRANCH;
                    OPC_JAL:             state_d = S_JUMP_LINK;
                    OPC_JALR:            state_d = S_EXEC_JALR;
                    OPC_LUI:             state_d = S_LUI_WB;
                    OPC_AUIPC:           state_d = S_ALU_WB;
                    OPC_FENCE:           state_d = S_FETCH;
                    default:             state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                alu_reg_en_s = 1'b1;
                imm_s        = (opcode_s == OPC_STORE) ? IMM_S : IMM_I;
                state_d      = (opcode_s == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_en_s = 1'b1;
                memsel_s = 1'b1;
                mode_s   = mode_from_funct3(funct3_s);
                if (mem_op_r) begin
                    mem_reg_en_s = 1'b1;
                    state_d      = S_LOAD_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_LOAD_WB: begin
                imm_s   = load_ext_from_funct3(funct3_s);
                rfm_s   = RF_SEXT;
                rf_we_s = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                mem_en_s = 1'b1;
                mem_we_s = 1'b1;
                memsel_s = 1'b1;
                mode_s   = mode_from_funct3(funct3_s);
                state_d  = mem_op_r ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                alu_reg_en_s = 1'b1;
                op2_s        = OP2_RS2;
                alu_s        = dec_alu_s;
                state_d      = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_reg_en_s = 1'b1;
                alu_s        = dec_alu_s;
                state_d      = S_ALU_WB;
            end
            S_ALU_WB: begin
                rfm_s   = RF_ALU;
                rf_we_s = 1'b1;
                state_d = S_FETCH;
            end
            S_LUI_WB: begin
                imm_s   = IMM_U;
                rfm_s   = RF_SEXT;
                rf_we_s = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                op2_s   = OP2_RS2;
                alu_s   = dec_alu_s;
                pc_en_s = branch_taken(funct3_s, zero);
                state_d = S_FETCH;
            end
            S_EXEC_JALR: begin
                alu_reg_en_s = 1'b1;
                state_d      = S_JUMP_LINK;
            end
            S_JUMP_LINK: begin
                op1_s   = OP1_OLD_PC;
                op2_s   = OP2_FOUR;
                arm_s   = 1'b1;
                rfm_s   = RF_ALU;
                rf_we_s = 1'b1;
                state_d = S_JUMP;
            end
            S_JUMP: begin
                pc_en_s = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign pc_enable          = reset & pc_en_s;
    assign old_pc_enable      = reset & old_pc_en_s;
    assign ir_reg_enable      = reset & ir_en_s;
    assign mem_reg_enable     = reset & mem_reg_en_s;
    assign alu_reg_enable     = reset & alu_reg_en_s;
    assign rf_we              = reset & rf_we_s;
    assign mem_enable         = reset & mem_en_s;
    assign mem_write_enable   = reset & mem_we_s;
    assign memsel_mux_select  = reset & memsel_s;
    assign alu_reg_mux_select = reset & arm_s;
    assign regfile_mux_select = reset ? rfm_s  : 2'b00;
    assign imm_src            = reset ? imm_s  : 4'd0;
    assign opsel1_select      = reset ? op1_s  : 2'b00;
    assign opsel2_select      = reset ? op2_s  : 2'b00;
    assign alu_sel            = reset ? alu_s  : 4'd0;
    assign instr_mode         = reset ? mode_s : 2'b00;
    assign halted             = halted_q;
    assign instret            = instret_q;

endmodule

// File: tb/tb_control_unit_module.sv
// Scoreboard bench: expected control vectors are queued as each cycle is driven
// and compared at the following falling edge.
module tb_control_unit_module;

    typedef struct packed {
        logic       pc_en, old_pc_en, ir_en, mreg_en, areg_en, rf_we;
        logic       mem_en, mem_we, memsel, arm;
        logic [1:0] rfm;
        logic [3:0] imm;
        logic [1:0] op1, op2;
        logic [3:0] alu;
        logic [1:0] mode;
        logic       halted;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir_reg_out;
    logic        zero, mem_op_r;
    logic        pc_enable, old_pc_enable, ir_reg_enable, mem_reg_enable, alu_reg_enable;
    logic        rf_we, mem_enable, mem_write_enable, memsel_mux_select, alu_reg_mux_select;
    logic [1:0]  regfile_mux_select, opsel1_select, opsel2_select, instr_mode;
    logic [3:0]  imm_src, alu_sel;
    logic        halted;
    logic [31:0] instret;

    ctl_t        obs;
    ctl_t        exp_q[$];
    logic [31:0] ret_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] ir_cnt = 32'd0;

    control_unit_module dut (
        .clk(clk), .reset(reset), .ir_reg_out(ir_reg_out), .zero(zero), .mem_op_r(mem_op_r),
        .pc_enable(pc_enable), .old_pc_enable(old_pc_enable), .ir_reg_enable(ir_reg_enable),
        .mem_reg_enable(mem_reg_enable), .alu_reg_enable(alu_reg_enable), .rf_we(rf_we),
        .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
        .memsel_mux_select(memsel_mux_select), .alu_reg_mux_select(alu_reg_mux_select),
        .regfile_mux_select(regfile_mux_select), .imm_src(imm_src),
        .opsel1_select(opsel1_select), .opsel2_select(opsel2_select), .alu_sel(alu_sel),
        .instr_mode(instr_mode), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    assign obs = {pc_enable, old_pc_enable, ir_reg_enable, mem_reg_enable, alu_reg_enable,
                  rf_we, mem_enable, mem_write_enable, memsel_mux_select, alu_reg_mux_select,
                  regfile_mux_select, imm_src, opsel1_select, opsel2_select, alu_sel,
                  instr_mode, halted};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            string t;
            ctl_t  e;
            logic [31:0] r;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            r = ret_q.pop_front();
            check_eq({t, ".ctl"}, 32'(obs), 32'(e));
            check_eq({t, ".instret"}, instret, r);
        end
    end

    function automatic ctl_t z();
        return '0;
    endfunction

    function automatic ctl_t c_fetch(input logic mop);
        ctl_t e = '0;
        e.mem_en = 1'b1;
        if (mop) begin
            e.ir_en = 1'b1; e.old_pc_en = 1'b1; e.pc_en = 1'b1;
            e.op1 = 2'b01; e.op2 = 2'b01; e.arm = 1'b1;
        end
        return e;
    endfunction

    function automatic ctl_t c_decode(input logic [3:0] imm);
        ctl_t e = '0;
        e.areg_en = 1'b1; e.op1 = 2'b10; e.imm = imm;
        return e;
    endfunction

    // Drive one cycle, queue its expectation, advance past the rising edge.
    task automatic cyc(input string tag, input logic [31:0] ins, input logic zr,
                       input logic mop, input ctl_t e, input logic ret);
        ir_reg_out = ins; zero = zr; mem_op_r = mop;
        tag_q.push_back(tag); exp_q.push_back(e); ret_q.push_back(ir_cnt);
        @(posedge clk); #1;
        ir_cnt = ir_cnt + {31'd0, ret};
    endtask

    task automatic run_rtype(input string tag, input logic [31:0] ins, input logic [3:0] alu);
        ctl_t e;
        cyc({tag, ".fetch"}, ins, 1'b0, 1'b1, c_fetch(1'b1), 1'b0);
        cyc({tag, ".decode"}, ins, 1'b0, 1'b0, c_decode(4'd3), 1'b0);
        e = z(); e.areg_en = 1'b1; e.op2 = 2'b10; e.alu = alu;
        cyc({tag, ".exec"}, ins, 1'b0, 1'b0, e, 1'b0);
        e = z(); e.rfm = 2'b01; e.rf_we = 1'b1;
        cyc({tag, ".wb"}, ins, 1'b0, 1'b0, e, 1'b1);
    endtask

    task automatic run_branch(input string tag, input logic [31:0] ins, input logic zr,
                              input logic [3:0] alu, input logic taken);
        ctl_t e;
        cyc({tag, ".fetch"}, ins, zr, 1'b1, c_fetch(1'b1), 1'b0);
        cyc({tag, ".decode"}, ins, zr, 1'b0, c_decode(4'd2), 1'b0);
        e = z(); e.op2 = 2'b10; e.alu = alu; e.pc_en = taken;
        cyc({tag, ".branch"}, ins, zr, 1'b0, e, 1'b1);
    endtask

    localparam logic [31:0] I_LB   = 32'h0000_8283;
    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;
    localparam logic [31:0] I_SRAI = 32'h4050_D193;
    localparam logic [31:0] I_BEQ  = 32'h0020_8463;
    localparam logic [31:0] I_BLTU = 32'h0020_E463;
    localparam logic [31:0] I_JAL  = 32'h0080_00EF;
    localparam logic [31:0] I_SW   = 32'h0020_A023;
    localparam logic [31:0] I_ECAL = 32'h0000_0073;

    initial begin
        ctl_t e;
        reset = 1'b0; ir_reg_out = 32'd0; zero = 1'b0; mem_op_r = 1'b0;
        @(posedge clk); #1;
        cyc("rst0", I_LB, 1'b1, 1'b1, z(), 1'b0);
        cyc("rst1", I_LB, 1'b0, 1'b1, z(), 1'b0);
        reset = 1'b1;

        // LB interrupted by reset while waiting in MEM_RD
        cyc("lb0.fetch_wait", I_LB, 1'b0, 1'b0, c_fetch(1'b0), 1'b0);
        cyc("lb0.fetch", I_LB, 1'b0, 1'b1, c_fetch(1'b1), 1'b0);
        cyc("lb0.decode", I_LB, 1'b0, 1'b0, c_decode(4'd3), 1'b0);
        e = z(); e.areg_en = 1'b1;
        cyc("lb0.memadr", I_LB, 1'b0, 1'b0, e, 1'b0);
        e = z(); e.mem_en = 1'b1; e.memsel = 1'b1; e.mode = 2'b10;
        cyc("lb0.memrd_wait", I_LB, 1'b0, 1'b0, e, 1'b0);
        reset = 1'b0;
        cyc("lb0.reset_mid", I_LB, 1'b0, 1'b1, z(), 1'b0);
        reset = 1'b1;

        // Complete LB
        cyc("lb.fetch_first", I_LB, 1'b0, 1'b1, c_fetch(1'b1), 1'b0);
        cyc("lb.decode", I_LB, 1'b0, 1'b0, c_decode(4'd3), 1'b0);
        e = z(); e.areg_en = 1'b1;
        cyc("lb.memadr", I_LB, 1'b0, 1'b0, e, 1'b0);
        e = z(); e.mem_en = 1'b1; e.memsel = 1'b1; e.mode = 2'b10; e.mreg_en = 1'b1;
        cyc("lb.memrd", I_LB, 1'b0, 1'b1, e, 1'b0);
        e = z(); e.imm = 4'd5; e.rfm = 2'b10; e.rf_we = 1'b1;
        cyc("lb.loadwb", I_LB, 1'b0, 1'b0, e, 1'b1);

        // ADD with three memory wait cycles in FETCH
        for (int i = 0; i < 3; i++) begin
            cyc("add.fetch_wait", I_ADD, 1'b0, 1'b0, c_fetch(1'b0), 1'b0);
        end
        run_rtype("add", I_ADD, 4'd0);
        run_rtype("sub", I_SUB, 4'd1);

        cyc("srai.fetch", I_SRAI, 1'b0, 1'b1, c_fetch(1'b1), 1'b0);
        cyc("srai.decode", I_SRAI, 1'b0, 1'b0, c_decode(4'd3), 1'b0);
        e = z(); e.areg_en = 1'b1; e.alu = 4'd7;
        cyc("srai.exec", I_SRAI, 1'b0, 1'b0, e, 1'b0);
        e = z(); e.rfm = 2'b01; e.rf_we = 1'b1;
        cyc("srai.wb", I_SRAI, 1'b0, 1'b0, e, 1'b1);

        run_branch("beq_t", I_BEQ, 1'b1, 4'd1, 1'b1);
        run_branch("beq_n", I_BEQ, 1'b0, 4'd1, 1'b0);
        run_branch("bltu_t", I_BLTU, 1'b0, 4'd9, 1'b1);

        cyc("jal.fetch", I_JAL, 1'b0, 1'b1, c_fetch(1'b1), 1'b0);
        cyc("jal.decode", I_JAL, 1'b0, 1'b0, c_decode(4'd4), 1'b0);
        e = z(); e.op1 = 2'b10; e.op2 = 2'b01; e.arm = 1'b1; e.rfm = 2'b01; e.rf_we = 1'b1;
        cyc("jal.link", I_JAL, 1'b0, 1'b0, e, 1'b0);
        e = z(); e.pc_en = 1'b1;
        cyc("jal.jump", I_JAL, 1'b0, 1'b0, e, 1'b1);

        cyc("sw.fetch", I_SW, 1'b0, 1'b1, c_fetch(1'b1), 1'b0);
        cyc("sw.decode", I_SW, 1'b0, 1'b0, c_decode(4'd3), 1'b0);
        e = z(); e.areg_en = 1'b1; e.imm = 4'd1;
        cyc("sw.memadr", I_SW, 1'b0, 1'b0, e, 1'b0);
        e = z(); e.mem_en = 1'b1; e.mem_we = 1'b1; e.memsel = 1'b1;
        cyc("sw.memwr_wait", I_SW, 1'b0, 1'b0, e, 1'b0);
        cyc("sw.memwr", I_SW, 1'b0, 1'b1, e, 1'b1);

        // ECALL halts; nothing may be enabled afterwards
        cyc("ecall.fetch", I_ECAL, 1'b0, 1'b1, c_fetch(1'b1), 1'b0);
        cyc("ecall.decode", I_ECAL, 1'b0, 1'b0, c_decode(4'd3), 1'b0);
        for (int i = 0; i < 100; i++) begin
            e = z(); e.halted = 1'b1;
            cyc("ecall.halt", I_ECAL, 1'($urandom_range(1)), 1'($urandom_range(1)), e, 1'b0);
        end

        reset = 1'b0;
        ir_cnt = 32'd0;
        cyc("rst2", I_ADD, 1'b0, 1'b1, z(), 1'b0);
        reset = 1'b1;
        cyc("rst2.fetch", I_ADD, 1'b0, 1'b0, c_fetch(1'b0), 1'b0);

        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
